// File: rtl/inst_loader_pkg.sv
// Shared types and helpers for the instruction loader and its byte packer.
package inst_loader_pkg;

  localparam int INST_W = 9;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WR   = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } ld_state_t;

  // Only bit 0 of the high byte carries instruction data; the rest must be zero.
  function automatic logic pad_bits_set(input logic [BYTE_W-1:0] b);
    return |b[BYTE_W-1:1];
  endfunction

endpackage

// File: rtl/inst_byte_packer.sv
// Latches the low byte of each instruction word, checks the high-byte pad bits
// and keeps a running XOR of every data byte of the current load.
module inst_byte_packer
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              take_lo,
  input  logic              take_hi,
  input  logic [BYTE_W-1:0] data,
  output logic [INST_W-1:0] word,
  output logic              pad_err,
  output logic [BYTE_W-1:0] csum
);

  logic [BYTE_W-1:0] lo_r;
  logic [BYTE_W-1:0] csum_r;

  // Word is only meaningful while the high byte is being accepted.
  assign word    = {data[0], lo_r};
  assign pad_err = take_hi && pad_bits_set(data);
  assign csum    = csum_r;

  // Low-byte latch and running checksum, restarted on every accepted Start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_r   <= 8'h00;
      csum_r <= 8'h00;
    end else if (clear) begin
      lo_r   <= 8'h00;
      csum_r <= 8'h00;
    end else begin
      if (take_lo) begin
        lo_r <= data;
      end
      if (take_lo || take_hi) begin
        csum_r <= csum_r ^ data;
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: packs a byte stream into 9-bit words written to instruction RAM.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per load.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int IW = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [IW:0]       Load_len,
  input  logic [BYTE_W-1:0] In_data,
  input  logic              In_valid,
  output logic              In_ready,
  output logic              Wr_en,
  output logic [IW-1:0]     Wr_addr,
  output logic [INST_W-1:0] Wr_data,
  output logic              Cpu_hold,
  output logic              Done,
  output logic              Err
);

  localparam logic [IW:0] MAX_LEN = {1'b1, {IW{1'b0}}};
  localparam logic [IW:0] ZERO_LEN = {(IW+1){1'b0}};

  ld_state_t         state_r;
  ld_state_t         state_nx_s;
  logic [IW:0]       len_r;
  logic [IW:0]       len_sat_s;
  logic [IW-1:0]     idx_r;
  logic              xfer_s;
  logic              start_acc_s;
  logic              last_s;
  logic              take_lo_s;
  logic              take_hi_s;
  logic              take_cs_s;
  logic              csum_bad_s;
  logic              pad_err_s;
  logic [INST_W-1:0] word_s;
  logic [BYTE_W-1:0] csum_s;
  logic              ready_nx_s;
  logic              hold_nx_s;
  logic              done_nx_s;
  logic              wr_en_nx_s;

  assign xfer_s      = In_valid && In_ready;
  assign start_acc_s = Start && ((state_r == IDLE) || (state_r == DONE));
  assign take_lo_s   = xfer_s && (state_r == LO);
  assign take_hi_s   = xfer_s && (state_r == HI);
  assign take_cs_s   = xfer_s && (state_r == CSUM);
  assign csum_bad_s  = take_cs_s && (In_data != csum_s);
  assign len_sat_s   = (Load_len > MAX_LEN) ? MAX_LEN : Load_len;
  assign last_s      = ({1'b0, idx_r} == (len_r - (IW+1)'(1)));

  inst_byte_packer u_packer (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .clear   (start_acc_s),
    .take_lo (take_lo_s),
    .take_hi (take_hi_s),
    .data    (In_data),
    .word    (word_s),
    .pad_err (pad_err_s),
    .csum    (csum_s)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_acc_s) state_nx_s = (len_sat_s == ZERO_LEN) ? DONE : LO;
        else             state_nx_s = state_r;
      end
      LO: begin
        if (xfer_s) state_nx_s = HI;
        else        state_nx_s = LO;
      end
      HI: begin
        if (xfer_s) state_nx_s = WR;
        else        state_nx_s = HI;
      end
      WR: begin
`ifdef INST_LOADER_CHECKSUM_EN
        if (last_s) state_nx_s = CSUM;
        else        state_nx_s = LO;
`else
        if (last_s) state_nx_s = DONE;
        else        state_nx_s = LO;
`endif
      end
      CSUM: begin
        if (xfer_s) state_nx_s = DONE;
        else        state_nx_s = CSUM;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    ready_nx_s = 1'b0;
    hold_nx_s  = 1'b0;
    done_nx_s  = 1'b0;
    wr_en_nx_s = 1'b0;
    case (state_nx_s)
      LO, HI, CSUM: begin
        ready_nx_s = 1'b1;
        hold_nx_s  = 1'b1;
      end
      WR: begin
        wr_en_nx_s = 1'b1;
        hold_nx_s  = 1'b1;
      end
      DONE:    done_nx_s  = 1'b1;
      IDLE:    done_nx_s  = 1'b0;
      default: done_nx_s  = 1'b0;
    endcase
  end

  // Load length and word index.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      len_r <= ZERO_LEN;
      idx_r <= {IW{1'b0}};
    end else if (start_acc_s) begin
      len_r <= len_sat_s;
      idx_r <= {IW{1'b0}};
    end else if ((state_r == WR) && !last_s) begin
      idx_r <= idx_r + IW'(1);
    end
  end

  // Registered outputs; Err is sticky until the next accepted Start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      In_ready <= 1'b0;
      Wr_en    <= 1'b0;
      Wr_addr  <= {IW{1'b0}};
      Wr_data  <= 9'h000;
      Cpu_hold <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      In_ready <= ready_nx_s;
      Wr_en    <= wr_en_nx_s;
      Cpu_hold <= hold_nx_s;
      Done     <= done_nx_s;
      if (wr_en_nx_s) begin
        Wr_addr <= idx_r;
        Wr_data <= word_s;
      end
      if (start_acc_s) begin
        Err <= 1'b0;
      end else if (pad_err_s || csum_bad_s) begin
        Err <= 1'b1;
      end
    end
  end

endmodule
